frequency_sweep_sequencer: RTL
==============================

Name: frequency_sweep_sequencer

Overview:
Sequences the H-bridge square-wave generator through a programmed frequency sweep for resonant-tank frequency-response testing. It owns the half-period word that drives the bridge counter. It steps that word from a start value to a stop value, holding each point for a programmed number of switching cycles. Period changes are applied only on bridge-cycle boundaries, and bridge enable is gated for the duration of the sweep.

Parameters:
W, 32, width of period words (half-period in i_clk cycles)
DW, 16, width of dwell count
PERIOD_RESET, 250, o_period value after reset

Ports:
i_clk  input  1  system clock (100 MHz bridge-counter clock)
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  one-cycle pulse; begins a sweep when idle
i_abort  input  1  level/pulse; terminates any sweep
i_period_start  input  W  first half-period of sweep
i_period_stop  input  W  last half-period of sweep
i_period_step  input  W  step magnitude (unsigned)
i_dwell  input  DW  bridge cycles held per point
i_cycle_end  input  1  one-cycle pulse when bridge counter wraps to 0
o_period  output  W  half-period to bridge counter
o_enable  output  1  bridge enable (ANDed into gate drive downstream)
o_busy  output  1  high in ARM or RUN
o_done  output  1  high in DONE
o_step_strobe  output  1  one-cycle pulse on each period update in RUN
o_step_idx  output  16  index of current sweep point (0 = start)

Behaviour:
- Reset (async, i_reset=1): state IDLE; o_period=PERIOD_RESET; o_enable, o_busy, o_done, o_step_strobe=0; o_step_idx=0; internal dwell count=0.
- All other state updates occur on the rising edge of i_clk. All outputs are registered.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - i_start=1 and i_abort=0 -> ARM.
  - Latch start/stop/step/dwell into shadow registers; later input changes are ignored until the next start.
  - o_period <= max(i_period_start, 1).
  - o_step_idx <= 0.
  - Direction is up if stop > start, otherwise down.
- ARM:
  - Wait for i_cycle_end.
  - On i_cycle_end -> RUN; o_enable=1 from the next cycle; dwell count=0.
- RUN, on each i_cycle_end:
  - dwell count += 1.
  - When dwell count reaches max(dwell, 1):
    - If o_period == stop (clamped) -> DONE.
    - Otherwise update o_period in the same edge so the new value governs the next bridge cycle. Clear dwell count, pulse o_step_strobe, increment o_step_idx (saturating at 0xFFFF).
- Step arithmetic (no wrap-around):
  - Up: next = (stop - cur <= step) ? stop : cur + step.
  - Down: next = (cur - stop <= step) ? stop : cur - step.
  - Result is floored at 1.
- Degenerate sweeps:
  - step==0 or start==stop: a single point, held for the dwell, then DONE.
  - dwell==0 behaves as dwell==1.
- DONE:
  - o_enable=0 and o_done=1; o_period holds its last value.
  - i_start -> ARM (new sweep, o_done cleared).
- Abort:
  - i_abort=1 in any state -> IDLE on the next edge; o_enable=0, o_done=0, o_busy=0.
  - o_period and o_step_idx retain their values.
  - Abort has priority over start and over i_cycle_end in the same cycle.
- i_start while in ARM or RUN is ignored.
- o_busy = (state==ARM or RUN); o_done = (state==DONE).
- Reset mid-sweep returns immediately to reset values; no sweep resumes after release.

Test Plan:
- Up sweep: start=100, stop=110, step=5, dwell=2, i_cycle_end every 200 clk.
  - o_period sequence is 100, 105, 110; o_step_strobe pulses 2×; o_step_idx ends at 2.
  - DONE is reached after the 6th i_cycle_end in RUN; o_enable falls the same edge o_done rises.
- Down sweep with clamp: start=100, stop=93, step=5, dwell=1.
  - o_period sequence is 100, 95, 93, then DONE.
  - No value below 93 ever appears.
- Abort mid-RUN, at point 1 of an up sweep:
  - Assert i_abort coincident with i_cycle_end -> IDLE next edge; o_enable=0.
  - o_period stays 105 (no update); o_step_idx stays 1.
- Degenerate sweeps:
  - start=stop=250, dwell=0: one i_cycle_end in RUN -> DONE; zero strobes.
  - step=0 with start≠stop: same result.
- i_start and i_abort in the same IDLE cycle -> remains IDLE.
  - A later i_start during RUN is ignored; the sweep completes unchanged.
- Assert i_reset asynchronously mid-RUN (between clock edges):
  - Outputs go immediately to o_period=250 and o_enable=0.
  - After release, the block stays IDLE until i_start.

Source files
------------

// File: rtl/frequency_sweep_sequencer.sv
// Steps the H-bridge half-period from a start to a stop value, holding each point for a
// programmed number of bridge cycles. Period changes land only on bridge-cycle boundaries.
module frequency_sweep_sequencer #(
    parameter int W            = 32,
    parameter int DW           = 16,
    parameter int PERIOD_RESET = 250
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [W-1:0]  i_period_start,
    input  logic [W-1:0]  i_period_stop,
    input  logic [W-1:0]  i_period_step,
    input  logic [DW-1:0] i_dwell,
    input  logic          i_cycle_end,
    output logic [W-1:0]  o_period,
    output logic          o_enable,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_step_strobe,
    output logic [15:0]   o_step_idx,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  stop_q;
    logic [W-1:0]  step_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_cnt;
    logic          up_q;

    logic [W-1:0]  start_c;
    logic [W-1:0]  stop_c;
    logic [W-1:0]  next_period;
    logic [DW-1:0] dwell_eff;
    logic [DW-1:0] dwell_inc;

    assign o_state = state;

    // A period of zero would stall the bridge counter, so both endpoints are floored at 1.
    assign start_c   = (i_period_start == '0) ? W'(1) : i_period_start;
    assign stop_c    = (i_period_stop == '0) ? W'(1) : i_period_stop;
    assign dwell_eff = (dwell_q == '0) ? DW'(1) : dwell_q;
    assign dwell_inc = dwell_cnt + DW'(1);

    // Distance-to-stop is compared before stepping so the result can never overshoot or wrap.
    always_comb begin
        next_period = o_period;
        if (up_q) begin
            next_period = ((stop_q - o_period) <= step_q) ? stop_q : (o_period + step_q);
        end else begin
            next_period = ((o_period - stop_q) <= step_q) ? stop_q : (o_period - step_q);
        end
        if (next_period == '0) begin
            next_period = W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            o_period      <= W'(PERIOD_RESET);
            o_enable      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_step_strobe <= 1'b0;
            o_step_idx    <= '0;
            dwell_cnt     <= '0;
            stop_q        <= '0;
            step_q        <= '0;
            dwell_q       <= '0;
            up_q          <= 1'b0;
        end else begin
            o_step_strobe <= 1'b0;
            if (i_abort) begin
                state    <= S_IDLE;
                o_enable <= 1'b0;
                o_busy   <= 1'b0;
                o_done   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (i_start) begin
                            state      <= S_ARM;
                            o_busy     <= 1'b1;
                            o_done     <= 1'b0;
                            o_enable   <= 1'b0;
                            stop_q     <= stop_c;
                            step_q     <= i_period_step;
                            dwell_q    <= i_dwell;
                            up_q       <= (i_period_stop > i_period_start);
                            o_period   <= start_c;
                            o_step_idx <= '0;
                            dwell_cnt  <= '0;
                        end
                    end
                    S_ARM: begin
                        if (i_cycle_end) begin
                            state     <= S_RUN;
                            o_enable  <= 1'b1;
                            dwell_cnt <= '0;
                        end
                    end
                    S_RUN: begin
                        if (i_cycle_end) begin
                            if (dwell_inc >= dwell_eff) begin
                                // A zero step can never reach stop, so it is a single-point sweep.
                                if (o_period == stop_q || step_q == '0) begin
                                    state     <= S_DONE;
                                    o_enable  <= 1'b0;
                                    o_busy    <= 1'b0;
                                    o_done    <= 1'b1;
                                    dwell_cnt <= dwell_inc;
                                end else begin
                                    o_period      <= next_period;
                                    dwell_cnt     <= '0;
                                    o_step_strobe <= 1'b1;
                                    if (o_step_idx != 16'hFFFF) begin
                                        o_step_idx <= o_step_idx + 16'd1;
                                    end
                                end
                            end else begin
                                dwell_cnt <= dwell_inc;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
